// File: rtl/sobel_pkg.sv
// Shared types and defaults for the Sobel datapath blocks
// (move_control, window_fetch).
package sobel_pkg;

    typedef enum logic [1:0] {
        DIR_RELOAD = 2'b00,
        DIR_RIGHT  = 2'b01,
        DIR_LEFT   = 2'b10,
        DIR_ROW    = 2'b11
    } dir_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        FULL  = 2'b01,
        PART  = 2'b10,
        DRAIN = 2'b11
    } fetch_state_t;

    localparam int DEF_PIX_W  = 8;
    localparam int DEF_ADDR_W = 8;
    localparam int WIN_N      = 3;

endpackage

// File: rtl/window_regs.sv
// 3x3 pixel window storage with indexed write and shift controls.
// A write lands before the shift so both can coincide on one edge.
module window_regs
    import sobel_pkg::*;
#(
    parameter int PIX_W = DEF_PIX_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     shift_left,
    input  logic                     shift_right,
    input  logic                     shift_up,
    input  logic                     wr_en,
    input  logic [1:0]               wr_row,
    input  logic [1:0]               wr_col,
    input  logic [PIX_W-1:0]         wr_data,
    output logic [9*PIX_W-1:0]       window
);

    logic [PIX_W-1:0] cells [WIN_N][WIN_N];
    logic [PIX_W-1:0] merged [WIN_N][WIN_N];
    logic [PIX_W-1:0] nxt [WIN_N][WIN_N];

    always_comb begin
        merged = cells;
        if (wr_en) begin
            merged[wr_row][wr_col] = wr_data;
        end
        nxt = merged;
        if (shift_left) begin
            for (int r = 0; r < WIN_N; r++) begin
                for (int c = 0; c < WIN_N - 1; c++) begin
                    nxt[r][c] = merged[r][c+1];
                end
            end
        end
        if (shift_right) begin
            for (int r = 0; r < WIN_N; r++) begin
                for (int c = 1; c < WIN_N; c++) begin
                    nxt[r][c] = merged[r][c-1];
                end
            end
        end
        if (shift_up) begin
            for (int r = 0; r < WIN_N - 1; r++) begin
                for (int c = 0; c < WIN_N; c++) begin
                    nxt[r][c] = merged[r+1][c];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cells <= '{default: '0};
        end else begin
            cells <= nxt;
        end
    end

    always_comb begin
        window = '0;
        for (int r = 0; r < WIN_N; r++) begin
            for (int c = 0; c < WIN_N; c++) begin
                window[(r*WIN_N+c)*PIX_W +: PIX_W] = cells[r][c];
            end
        end
    end

endmodule

// File: rtl/window_fetch.sv
// Memory-side reader keeping a 3x3 Sobel window current, by full
// reload (9 reads) or shift plus edge fetch (3 reads).
module window_fetch
    import sobel_pkg::*;
#(
    parameter int PIX_W  = DEF_PIX_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic                 clk,
    input  logic                 n_reset,
    input  logic [11:0]          width,
    input  logic [ADDR_W-1:0]    addr_r,
    input  logic [1:0]           direction,
    input  logic                 fetch_full,
    input  logic                 fetch_step,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic                 mem_ren,
    input  logic [PIX_W-1:0]     mem_rdata,
    output logic [9*PIX_W-1:0]   window,
    output logic                 window_valid,
    output logic                 busy
);

    fetch_state_t state, nstate;

    logic [ADDR_W-1:0] base, wid;
    dir_t              dir;
    logic [1:0]        row, col;
    logic [1:0]        nrow, ncol;
    logic [1:0]        srow, scol;
    logic              last;

    logic              pend_v;
    logic [1:0]        pend_row, pend_col;

    logic              can_accept, req, req_full;
    logic              shl, shr, shu;
    logic              unused;

    assign unused = ^width[11:ADDR_W];

    function automatic logic [ADDR_W-1:0] row_off(
        input logic [ADDR_W-1:0] w,
        input logic [1:0]        r
    );
        row_off = '0;
        if (r == 2'd1) row_off = w;
        if (r == 2'd2) row_off = {w[ADDR_W-2:0], 1'b0};
    endfunction

    // DRAIN is the window_valid cycle; the FSM is back in IDLE on its edge
    assign can_accept = (state == IDLE) || (state == DRAIN);
    assign req        = can_accept && (fetch_full || fetch_step);
    assign req_full   = fetch_full || (direction == DIR_RELOAD);

    assign mem_ren      = (state == FULL) || (state == PART);
    assign window_valid = (state == DRAIN);
    assign busy         = (state != IDLE);

    always_comb begin
        srow = 2'd0;
        scol = 2'd0;
        shl  = 1'b0;
        shr  = 1'b0;
        shu  = 1'b0;
        if (req && !req_full) begin
            unique case (dir_t'(direction))
                DIR_RIGHT: begin scol = 2'd2; shl = 1'b1; end
                DIR_LEFT:  shr = 1'b1;
                DIR_ROW:   begin srow = 2'd2; shu = 1'b1; end
                default:   ;
            endcase
        end
    end

    always_comb begin
        nrow = row;
        ncol = col;
        last = 1'b0;
        if (state == FULL) begin
            last = (row == 2'd2) && (col == 2'd2);
            if (col == 2'd2) begin
                nrow = row + 2'd1;
                ncol = 2'd0;
            end else begin
                ncol = col + 2'd1;
            end
        end else if (dir == DIR_ROW) begin
            last = (col == 2'd2);
            ncol = col + 2'd1;
        end else begin
            last = (row == 2'd2);
            nrow = row + 2'd1;
        end
    end

    always_comb begin
        nstate = state;
        unique case (state)
            IDLE, DRAIN: begin
                if (req) nstate = req_full ? FULL : PART;
                else     nstate = IDLE;
            end
            FULL, PART: begin
                if (last) nstate = DRAIN;
            end
            default: nstate = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge n_reset) begin
        if (n_reset) begin
            state    <= IDLE;
            base     <= '0;
            wid      <= '0;
            dir      <= DIR_RELOAD;
            row      <= '0;
            col      <= '0;
            mem_addr <= '0;
            pend_v   <= 1'b0;
            pend_row <= '0;
            pend_col <= '0;
        end else begin
            state    <= nstate;
            pend_v   <= mem_ren;
            pend_row <= row;
            pend_col <= col;
            if (req) begin
                base     <= addr_r;
                wid      <= width[ADDR_W-1:0];
                dir      <= dir_t'(direction);
                row      <= srow;
                col      <= scol;
                mem_addr <= addr_r + row_off(width[ADDR_W-1:0], srow)
                            + ADDR_W'(scol);
            end else if (mem_ren && !last) begin
                row      <= nrow;
                col      <= ncol;
                mem_addr <= base + row_off(wid, nrow) + ADDR_W'(ncol);
            end
        end
    end

    window_regs #(
        .PIX_W (PIX_W)
    ) u_regs (
        .clk         (clk),
        .rst         (n_reset),
        .shift_left  (shl),
        .shift_right (shr),
        .shift_up    (shu),
        .wr_en       (pend_v),
        .wr_row      (pend_row),
        .wr_col      (pend_col),
        .wr_data     (mem_rdata),
        .window      (window)
    );

endmodule
